data_demux_1to2: RTL and testbench

Registered 1-to-2 stream demultiplexer with valid/ready handshakes on all three ports: the inverse of the 2-to-1 datapath select. It sits between a single producer (input fetch or PE result path) and two consumers (ping-pong line buffers or two compute lanes). Each word is routed either by a per-word select bit or by an automatic ping-pong schedule that switches destination every `BURST_LEN` words. Each output has a one-entry register slice, so latency is one cycle and throughput is one word per cycle.

---
 rtl/data_demux_1to2_pkg.sv | 12 +
 rtl/reg_slice_1e.sv | 35 +++
 rtl/data_demux_1to2.sv | 95 +++++++++
 tb/tb_data_demux_1to2.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_demux_1to2_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer: datapath width and
// the ping-pong destination encoding.
package data_demux_1to2_pkg;

    localparam int INTERNAL_BITS = 32;

    typedef enum logic {
        DST0 = 1'b0,
        DST1 = 1'b1
    } dst_e;

endpackage

// File: rtl/reg_slice_1e.sv
// One-entry valid/ready register slice. A load overwrites the entry, otherwise
// a handshake on the output side empties it.
module reg_slice_1e #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              free
);

    // The entry can take a new word if it is empty or being emptied this cycle.
    assign free = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the data register is reset as well, so the output bus reads
            // as zero after reset instead of holding stale contents.
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/data_demux_1to2.sv
// Registered 1-to-2 stream demultiplexer: routes each word by in_sel or by a
// ping-pong schedule that switches destination every BURST_LEN words.
module data_demux_1to2
    import data_demux_1to2_pkg::*;
#(
    parameter int DATA_W    = INTERNAL_BITS,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              cur_dst,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    dst_e             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dst;
    logic             free0, free1;
    logic             accept;

    assign cur_dst  = (state_q == DST1);
    assign word_cnt = cnt_q;

    // Back-pressure on the chosen destination stalls the input; there is no
    // fall-back to the other slot, so ordering stays trivially intact.
    assign dst      = mode ? cur_dst : in_sel;
    assign in_ready = rst_n && (dst ? free1 : free0);
    assign accept   = in_valid && in_ready;

    reg_slice_1e #(.DATA_W(DATA_W)) u_slice0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept && !dst),
        .load_data (in_data),
        .out_valid (out0_valid),
        .out_ready (out0_ready),
        .out_data  (out0_data),
        .free      (free0)
    );

    reg_slice_1e #(.DATA_W(DATA_W)) u_slice1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept && dst),
        .load_data (in_data),
        .out_valid (out1_valid),
        .out_ready (out1_ready),
        .out_data  (out1_data),
        .free      (free1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DST0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults come first so every path assigns the next-state signals
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!mode) begin
            // Explicit routing keeps the schedule parked, so re-entry starts fresh.
            state_d = DST0;
            cnt_d   = '0;
        end else if (accept) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d   = '0;
                state_d = (state_q == DST0) ? DST1 : DST0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_data_demux_1to2.sv
// Scoreboard bench for data_demux_1to2 with BURST_LEN=4: stimulus pushes the
// expected word per destination, a negedge monitor pops on each transfer.
module tb_data_demux_1to2;

    localparam int DW    = 32;
    localparam int BURST = 4;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_sel;
    logic          out0_valid, out0_ready;
    logic [DW-1:0] out0_data;
    logic          out1_valid, out1_ready;
    logic [DW-1:0] out1_data;
    logic          cur_dst;
    logic [CW-1:0] word_cnt;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [DW-1:0] exp0[$];
    logic [DW-1:0] exp1[$];
    logic          m_dst;
    int            m_cnt;

    data_demux_1to2 #(.DATA_W(DW), .BURST_LEN(BURST), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cur_dst    (cur_dst),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [DW-1:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, expected no such event", name, act);
    endtask

    // Monitor: a word seen with valid and ready at the negedge transfers at the next posedge.
    always @(negedge clk) begin
        logic [DW-1:0] w;
        if (rst_n === 1'b1) begin
            if (out0_valid && out0_ready) begin
                if (exp0.size() == 0) fail_now("out0_unexpected", out0_data);
                else begin
                    w = exp0.pop_front();
                    check("out0_data", out0_data, w);
                end
            end
            if (out1_valid && out1_ready) begin
                if (exp1.size() == 0) fail_now("out1_unexpected", out1_data);
                else begin
                    w = exp1.pop_front();
                    check("out1_data", out1_data, w);
                end
            end
        end
    end

    task automatic set_mode(input logic v);
        mode = v;
        if (!v) begin
            m_dst = 1'b0;
            m_cnt = 0;
        end
    endtask

    // Drive one word, wait (bounded) for acceptance, record the expected destination.
    task automatic push_word(input logic sel, input logic [DW-1:0] d);
        int   waited;
        logic dst;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout", d);
            in_valid = 1'b0;
        end else begin
            dst = mode ? m_dst : sel;
            if (dst) exp1.push_back(d);
            else     exp0.push_back(d);
            if (mode) begin
                if (m_cnt == BURST - 1) begin
                    m_cnt = 0;
                    m_dst = ~m_dst;
                end else begin
                    m_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n      = 1'b0;
        mode       = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        m_dst      = 1'b0;
        m_cnt      = 0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out0_valid", out0_valid, 0);
        check("rst_out1_valid", out1_valid, 0);
        check("rst_out0_data", out0_data, 0);
        check("rst_out1_data", out1_data, 0);
        check("rst_cur_dst", cur_dst, 0);
        check("rst_word_cnt", word_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready_sel0", in_ready, 1);
        in_sel = 1'b1;
        #1;
        check("post_rst_in_ready_sel1", in_ready, 1);
        @(posedge clk); #1;

        // Mode 0, readies high: one-cycle latency, no stall
        c0 = cyc;
        push_word(1'b0, 32'h11);
        check("m0_lat_valid0", out0_valid, 1);
        check("m0_lat_data0", out0_data, 32'h11);
        push_word(1'b1, 32'h22);
        check("m0_lat_data1", out1_data, 32'h22);
        push_word(1'b0, 32'h33);
        check("m0_no_stall_cycles", cyc - c0, 3);
        repeat (2) @(posedge clk); #1;

        // Mode 0 back-pressure on out0
        out0_ready = 1'b0;
        push_word(1'b0, 32'hA1);
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'hA2;
        @(negedge clk);
        check("bp_in_ready_stalled", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        push_word(1'b1, 32'hB1);
        check("bp_out0_held", out0_data, 32'hA1);
        fork
            push_word(1'b0, 32'hA2);
            begin
                repeat (3) @(posedge clk);
                #1 out0_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;

        // Mode 1 ping-pong, BURST_LEN = 4, words 0..9
        set_mode(1'b1);
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            push_word(1'b1, DW'(i));
            if (i == 3 || i == 7) check("pp_cur_dst_toggle", cur_dst, m_dst);
            check("pp_word_cnt", word_cnt, DW'(m_cnt));
        end
        check("pp_throughput_cycles", cyc - c0, 10);
        check("pp_final_word_cnt", word_cnt, 2);
        check("pp_final_cur_dst", cur_dst, 0);
        repeat (2) @(posedge clk); #1;

        // Mode 1 -> 0 -> 1 mid-burst
        set_mode(1'b0);
        @(posedge clk); #1;
        set_mode(1'b1);
        for (int i = 0; i < 6; i++) push_word(1'b0, 32'h100 + DW'(i));
        check("mid_cur_dst", cur_dst, 1);
        check("mid_word_cnt", word_cnt, 2);
        set_mode(1'b0);
        @(posedge clk); #1;
        check("m0_forced_cur_dst", cur_dst, 0);
        check("m0_forced_word_cnt", word_cnt, 0);
        set_mode(1'b1);
        push_word(1'b1, 32'h200);
        check("reentry_out0_valid", out0_valid, 1);
        check("reentry_out0_data", out0_data, 32'h200);
        repeat (3) @(posedge clk); #1;

        // Reset with both slots full and readies low
        set_mode(1'b0);
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        push_word(1'b0, 32'hC0);
        push_word(1'b1, 32'hC1);
        check("full_out0_valid", out0_valid, 1);
        check("full_out1_valid", out1_valid, 1);
        rst_n = 1'b0;
        exp0.delete();
        exp1.delete();
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("midrst_out0_valid", out0_valid, 0);
        check("midrst_out1_valid", out1_valid, 0);
        check("midrst_out0_data", out0_data, 0);
        rst_n = 1'b1;
        m_dst = 1'b0;
        m_cnt = 0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        @(negedge clk);
        check("midrst_release_in_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        check("no_stale_out0", out0_valid, 0);
        check("no_stale_out1", out1_valid, 0);

        check("drained_out0", DW'(exp0.size()), 0);
        check("drained_out1", DW'(exp1.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
